lcd_text_writer: RTL and testbench
==================================

LCD_TEXT_WRITER -- requirements
Module: lcd_text_writer

Interface
REQ-001 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port char_in, input, 8, ASCII byte offered by the upstream source.
REQ-004 SHALL have port char_valid, input, 1, char_in holds a byte.
REQ-005 SHALL have port char_ready, output, 1, block accepts char_in this cycle; transfer occurs when char_valid & char_ready.
REQ-006 SHALL have port waddr, output, 5, 32-entry character RAM write address; bit 4 selects row, bits 3:0 select column.
REQ-007 SHALL have port din, output, 8, character RAM write data.
REQ-008 SHALL have port we, output, 1, character RAM write enable; one write per asserted cycle.
REQ-009 SHALL have port cursor, output, 5, current write position; same encoding as waddr.
REQ-010 SHALL have port busy, output, 1, a multi-cycle clear is in progress.

Function
REQ-011 SHALL drive waddr, din and we from registers; a write caused by an accepted byte appears exactly one cycle after the transfer cycle.
REQ-012 SHALL implement states IDLE, CLR_ALL and CLR_LINE; char_ready SHALL be 1 only in IDLE, and busy SHALL be 1 only in CLR_ALL or CLR_LINE.
REQ-013 SHALL, in IDLE, on a printable byte (0x20-0x7E), write it at cursor and advance the column by 1.
REQ-014 SHALL, on 0x0D (CR), set column to 0 with no write.
REQ-015 SHALL, on 0x0A (LF), toggle the row, set column to 0, and enter CLR_LINE.
REQ-016 SHALL, in CLR_LINE, write 0x20 to the 16 addresses of the new row, columns 0..15 in ascending order on consecutive cycles, then return to IDLE.
REQ-017 SHALL, on 0x08 (BS) with column > 0, decrement the column and write 0x20 at the new cursor; with column 0 it SHALL do nothing.
REQ-018 SHALL, on 0x0C (FF), set cursor to 0 and enter CLR_ALL.
REQ-019 SHALL, in CLR_ALL, write 0x20 to addresses 0..31 in ascending order on 32 consecutive cycles, then return to IDLE.
REQ-020 SHALL accept and discard any other byte value (0x00-0x07, 0x09, 0x0B, 0x0E-0x1F, 0x7F-0xFF) with no write and no cursor change.
REQ-021 SHALL hold we at 0 in any cycle not specified above as a write.
REQ-022 SHALL make cursor reflect the post-update position in the cycle after the transfer.
REQ-023 SHALL never drop or duplicate a byte: a byte held with char_valid=1 while char_ready=0 SHALL be consumed once when IDLE is reached.

Reset
REQ-024 SHALL, when reset is asserted, set cursor=0, we=0, waddr=0, din=0x20, char_ready=0, and enter CLR_ALL.
REQ-025 SHALL run a full 32-cycle CLR_ALL after reset deasserts, so the display starts blank.
REQ-026 SHALL, when reset is asserted mid-clear or mid-write, abandon the operation and restart CLR_ALL from address 0 after reset deasserts.

Configuration
REQ-027 SHALL honour macro LCD_TEXT_WRITER_AUTOWRAP_EN.
REQ-028 SHALL, with the macro defined, after writing a printable byte at column 15 move cursor to column 0 of the other row (31 wraps to 0, 15 wraps to 16), without clearing that row.
REQ-029 SHALL, without the macro, after writing a printable byte at column 15 leave the cursor at column 15, so further printables overwrite column 15 until CR, LF, BS or FF.

Verification
REQ-030 SHALL cover: reset released -> busy=1 for 32 cycles, writes of 0x20 to addresses 0..31 in order, then char_ready=1 and cursor=0.
REQ-031 SHALL cover: "HI" sent back-to-back from cursor 0 -> writes (0,0x48) then (1,0x49), each one cycle after its transfer; cursor=2.
REQ-032 SHALL cover: cursor=5, send 0x0A -> cursor=16, 16 writes of 0x20 to addresses 16..31, char_ready=0 throughout and held char_valid byte consumed once afterwards.
REQ-033 SHALL cover: cursor=16, send 0x08 -> no write, cursor=16; then cursor=17, send 0x08 -> write (16,0x20), cursor=16.
REQ-034 SHALL cover: cursor=15, send 'A' then 'B' -> with AUTOWRAP_EN writes (15,'A'),(16,'B'), cursor=17; without it writes (15,'A'),(15,'B'), cursor=15.
REQ-035 SHALL cover: reset pulsed at the tenth write of CLR_ALL -> after release, clear restarts at address 0 and completes all 32 writes.

Source files
------------

// File: rtl/lcd_text_writer.sv
// Streams ASCII bytes into a 2x16 character RAM, handling CR/LF/BS/FF control codes.
// Optional: define LCD_TEXT_WRITER_AUTOWRAP_EN to wrap the cursor to the other row after column 15.
module lcd_text_writer (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [4:0] waddr,
  output logic [7:0] din,
  output logic       we,
  output logic [4:0] cursor,
  output logic       busy
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;
  localparam logic [DW-1:0] CH_SPACE = 8'h20;
  localparam logic [DW-1:0] CH_TILDE = 8'h7E;
  localparam logic [DW-1:0] CH_BS    = 8'h08;
  localparam logic [DW-1:0] CH_LF    = 8'h0A;
  localparam logic [DW-1:0] CH_FF    = 8'h0C;
  localparam logic [DW-1:0] CH_CR    = 8'h0D;

  typedef enum logic [1:0] {IDLE, CLR_ALL, CLR_LINE} state_t;

  state_t          r_state, w_state;
  logic [AW-1:0]   r_cnt, w_cnt;
  logic [AW-1:0]   r_cursor, w_cursor;
  logic [AW-1:0]   r_waddr, w_waddr;
  logic [DW-1:0]   r_din, w_din;
  logic            r_we, w_we;
  logic            r_ready, w_ready;
  logic            r_busy, w_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= CLR_ALL;
      r_cnt    <= '0;
      r_cursor <= '0;
      r_waddr  <= '0;
      r_din    <= CH_SPACE;
      r_we     <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b1;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_cursor <= w_cursor;
      r_waddr  <= w_waddr;
      r_din    <= w_din;
      r_we     <= w_we;
      r_ready  <= w_ready;
      r_busy   <= w_busy;
    end
  end

  // Next-state, cursor update and RAM write decode.
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_cursor = r_cursor;
    w_waddr  = r_waddr;
    w_din    = r_din;
    w_we     = 1'b0;
    case (r_state)
      IDLE: begin
        if (char_valid) begin
          if (char_in >= CH_SPACE && char_in <= CH_TILDE) begin
            w_we    = 1'b1;
            w_waddr = r_cursor;
            w_din   = char_in;
            if (r_cursor[3:0] != 4'hF) begin
              w_cursor = r_cursor + AW'(1);
            end
`ifdef LCD_TEXT_WRITER_AUTOWRAP_EN
            else begin
              w_cursor = {~r_cursor[4], 4'h0};
            end
`endif
          end else begin
            case (char_in)
              CH_CR: w_cursor = {r_cursor[4], 4'h0};
              CH_LF: begin
                w_cursor = {~r_cursor[4], 4'h0};
                w_cnt    = '0;
                w_state  = CLR_LINE;
              end
              CH_BS: begin
                if (r_cursor[3:0] != 4'h0) begin
                  w_cursor = r_cursor - AW'(1);
                  w_we     = 1'b1;
                  w_waddr  = r_cursor - AW'(1);
                  w_din    = CH_SPACE;
                end
              end
              CH_FF: begin
                w_cursor = '0;
                w_cnt    = '0;
                w_state  = CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      CLR_ALL: begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
        w_din   = CH_SPACE;
        w_cnt   = r_cnt + AW'(1);
        if (r_cnt == AW'(31)) w_state = IDLE;
      end
      CLR_LINE: begin
        // Row comes from the cursor, which the LF already moved.
        w_we    = 1'b1;
        w_waddr = {r_cursor[4], r_cnt[3:0]};
        w_din   = CH_SPACE;
        w_cnt   = r_cnt + AW'(1);
        if (r_cnt[3:0] == 4'hF) w_state = IDLE;
      end
      default: begin
        w_state = CLR_ALL;
        w_cnt   = '0;
      end
    endcase
    w_ready = (w_state == IDLE);
    w_busy  = (w_state == CLR_ALL) || (w_state == CLR_LINE);
  end

  assign char_ready = r_ready;
  assign busy       = r_busy;
  assign waddr      = r_waddr;
  assign din        = r_din;
  assign we         = r_we;
  assign cursor     = r_cursor;

endmodule

// File: tb/tb_lcd_text_writer.sv
// Directed bench for lcd_text_writer: reset clear, printables, control codes, back-pressure, reset mid-clear.
module tb_lcd_text_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic [4:0] waddr;
  logic [7:0] din;
  logic       we;
  logic [4:0] cursor;
  logic       busy;

  int total = 0;
  int bad   = 0;

  lcd_text_writer dut (
    .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .waddr(waddr), .din(din), .we(we),
    .cursor(cursor), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle transfer of a byte; outputs are sampled just after the transfer edge.
  task automatic send(input logic [7:0] b);
    char_in    = b;
    char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
  endtask

  task automatic check_wr(input string tag, input logic [4:0] a, input logic [7:0] d);
    check({tag, "_we"}, we, 1'b1);
    check({tag, "_addr"}, waddr, a);
    check({tag, "_din"}, din, d);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (char_ready !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check("idle_timeout", char_ready, 1'b1);
  endtask

  initial begin
    reset      = 1'b1;
    char_in    = 8'h00;
    char_valid = 1'b0;
    repeat (2) tick();
    check("rst_cursor", cursor, 5'd0);
    check("rst_we", we, 1'b0);
    check("rst_waddr", waddr, 5'd0);
    check("rst_din", din, 8'h20);
    check("rst_ready", char_ready, 1'b0);
    check("rst_busy", busy, 1'b1);

    // Power-up clear
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check("clr_busy", busy, 1'b1);
      tick();
      check_wr("clr", 5'(i), 8'h20);
    end
    check("clr_ready", char_ready, 1'b1);
    check("clr_busy_end", busy, 1'b0);
    check("clr_cursor", cursor, 5'd0);
    tick();
    check("clr_we_off", we, 1'b0);

    // "HI" back-to-back
    char_in = 8'h48; char_valid = 1'b1;
    tick();
    check_wr("h", 5'd0, 8'h48);
    check("h_cursor", cursor, 5'd1);
    char_in = 8'h49;
    tick();
    char_valid = 1'b0;
    check_wr("i", 5'd1, 8'h49);
    check("i_cursor", cursor, 5'd2);
    tick();
    check("hi_we_off", we, 1'b0);

    // Discarded bytes
    send(8'h07);
    check("disc07_we", we, 1'b0);
    send(8'h7F);
    check("disc7f_we", we, 1'b0);
    send(8'hFF);
    check("discff_we", we, 1'b0);
    check("disc_cursor", cursor, 5'd2);

    // Advance to 5 then LF with a byte held during the line clear
    send(8'h61); send(8'h62); send(8'h63);
    check("c5_cursor", cursor, 5'd5);
    char_in = 8'h0A; char_valid = 1'b1;
    tick();
    check("lf_cursor", cursor, 5'd16);
    check("lf_we", we, 1'b0);
    check("lf_busy", busy, 1'b1);
    char_in = 8'h5A;
    for (int i = 0; i < 16; i++) begin
      check("lf_ready_low", char_ready, 1'b0);
      tick();
      check_wr("lfclr", 5'(16 + i), 8'h20);
    end
    check("lf_ready", char_ready, 1'b1);
    tick();
    char_valid = 1'b0;
    check_wr("held", 5'd16, 8'h5A);
    check("held_cursor", cursor, 5'd17);
    tick();
    check("held_once", we, 1'b0);
    check("held_cursor2", cursor, 5'd17);

    // CR then BS at column 0, then BS at column 1
    send(8'h0D);
    check("cr_we", we, 1'b0);
    check("cr_cursor", cursor, 5'd16);
    send(8'h08);
    check("bs0_we", we, 1'b0);
    check("bs0_cursor", cursor, 5'd16);
    send(8'h71);
    check("q_cursor", cursor, 5'd17);
    send(8'h08);
    check_wr("bs1", 5'd16, 8'h20);
    check("bs1_cursor", cursor, 5'd16);

    // FF clears everything; then fill to column 15 and probe the edge
    send(8'h0C);
    check("ff_cursor", cursor, 5'd0);
    check("ff_busy", busy, 1'b1);
    wait_idle();
    for (int i = 0; i < 15; i++) send(8'h2E);
    check("c15_cursor", cursor, 5'd15);
    send(8'h41);
    check_wr("a15", 5'd15, 8'h41);
    send(8'h42);
`ifdef LCD_TEXT_WRITER_AUTOWRAP_EN
    check_wr("b_wrap", 5'd16, 8'h42);
    check("b_cursor", cursor, 5'd17);
`else
    check_wr("b_nowrap", 5'd15, 8'h42);
    check("b_cursor", cursor, 5'd15);
`endif

    // Reset in the middle of CLR_ALL, at the tenth write
    reset = 1'b1;
    tick();
    check("rst2_cursor", cursor, 5'd0);
    reset = 1'b0;
    repeat (10) tick();
    check_wr("tenth", 5'd9, 8'h20);
    reset = 1'b1;
    tick();
    check("midrst_we", we, 1'b0);
    check("midrst_waddr", waddr, 5'd0);
    check("midrst_busy", busy, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick();
      check_wr("reclr", 5'(i), 8'h20);
    end
    check("reclr_ready", char_ready, 1'b1);
    check("reclr_cursor", cursor, 5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
